// File: rtl/rx_os_substate_tracker.sv
// Rx LTSSM substate engine: counts consecutive TS1/TS2 per substate, flags exit via finishRx/gotoRx.
// Optional substate timeout compiled in with RX_SUBSTATE_TIMEOUT_EN.
module rx_os_substate_tracker #(
  parameter int POLL_ACTIVE_TARGET = 8,
  parameter int POLL_CFG_TARGET    = 8,
  parameter int LW_START_TARGET    = 2,
  parameter int TMO_24MS           = 24000000,
  parameter int TMO_48MS           = 48000000,
  parameter logic [7:0] PAD_SYM    = 8'hF7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] substateRx,
  input  logic       osValid,
  input  logic [1:0] osType,
  input  logic [7:0] osLinkNum,
  input  logic [7:0] osLaneNum,
  output logic       finishRx,
  output logic [3:0] gotoRx,
  output logic [7:0] linkNumberOutRx,
  output logic       writeLinkNumberRx,
  output logic [3:0] osCount
);
  localparam logic [3:0] DETECT_QUIET = 4'd0;
  localparam logic [3:0] POLL_ACTIVE  = 4'd2;
  localparam logic [3:0] POLL_CFG     = 4'd3;
  localparam logic [3:0] LW_START     = 4'd4;
  localparam logic [3:0] LW_ACCEPT    = 4'd5;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;
  state_t state, nextState;

  logic [3:0] prevSub, count, nextCount, nextGoto, target, targetGoto;
  logic [7:0] capLink, nextCapLink, nextLinkOut;
  logic       nextFinish, nextWrite;
  logic       subChange, handled, isTs1, isTs2, lwForm, match, runStart, runDone;
`ifdef RX_SUBSTATE_TIMEOUT_EN
  logic [25:0] timer, nextTimer, tmoLimit;
  logic        timeout;
`endif

  assign osCount = count;

  // Per-substate match rule, target count and exit substate
  always_comb begin
    subChange  = (substateRx != prevSub);
    handled    = (substateRx == POLL_ACTIVE) || (substateRx == POLL_CFG) || (substateRx == LW_START);
    isTs1      = (osType == 2'd1);
    isTs2      = (osType == 2'd2);
    lwForm     = isTs1 && (osLinkNum != PAD_SYM) && (osLaneNum == PAD_SYM);
    match      = 1'b0;
    runStart   = 1'b0;
    target     = 4'd15;
    targetGoto = DETECT_QUIET;
    case (substateRx)
      POLL_ACTIVE: begin
        match      = isTs1 || isTs2;
        target     = 4'(POLL_ACTIVE_TARGET);
        targetGoto = POLL_CFG;
      end
      POLL_CFG: begin
        match      = isTs2;
        target     = 4'(POLL_CFG_TARGET);
        targetGoto = LW_START;
      end
      LW_START: begin
        match      = lwForm && ((count == 4'd0) || (osLinkNum == capLink));
        runStart   = lwForm;
        target     = 4'(LW_START_TARGET);
        targetGoto = LW_ACCEPT;
      end
      default: ;
    endcase
  end

  always_comb begin
    nextState   = state;
    nextCount   = count;
    nextCapLink = capLink;
    nextFinish  = finishRx;
    nextGoto    = gotoRx;
    nextWrite   = 1'b0;
    nextLinkOut = linkNumberOutRx;
    runDone     = 1'b0;
`ifdef RX_SUBSTATE_TIMEOUT_EN
    nextTimer   = timer;
    tmoLimit    = (substateRx == POLL_CFG) ? 26'(TMO_48MS) : 26'(TMO_24MS);
    timeout     = (timer >= tmoLimit - 26'd1);
`endif
    if (subChange) begin
      // Strobes in the change cycle are dropped on purpose
      nextState  = handled ? S_COUNT : S_IDLE;
      nextCount  = 4'd0;
      nextFinish = 1'b0;
`ifdef RX_SUBSTATE_TIMEOUT_EN
      nextTimer  = 26'd0;
`endif
    end else if (state == S_COUNT) begin
`ifdef RX_SUBSTATE_TIMEOUT_EN
      if (timer != '1) nextTimer = timer + 26'd1;
`endif
      if (osValid) begin
        if (match) begin
          if (count != 4'd15) nextCount = count + 4'd1;
          if (count == 4'd0) nextCapLink = osLinkNum;
        end else if (runStart) begin
          nextCount   = 4'd1;
          nextCapLink = osLinkNum;
        end else begin
          nextCount = 4'd0;
        end
        runDone = (match || runStart) && (nextCount >= target);
      end
      // Count completion takes priority over a coincident timeout
      if (runDone) begin
        nextState  = S_DONE;
        nextFinish = 1'b1;
        nextGoto   = targetGoto;
        if (substateRx == LW_START) begin
          nextWrite   = 1'b1;
          nextLinkOut = nextCapLink;
        end
      end
`ifdef RX_SUBSTATE_TIMEOUT_EN
      else if (timeout) begin
        nextState  = S_DONE;
        nextFinish = 1'b1;
        nextGoto   = DETECT_QUIET;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      prevSub           <= DETECT_QUIET;
      count             <= 4'd0;
      capLink           <= 8'd0;
      finishRx          <= 1'b0;
      gotoRx            <= DETECT_QUIET;
      linkNumberOutRx   <= 8'd0;
      writeLinkNumberRx <= 1'b0;
`ifdef RX_SUBSTATE_TIMEOUT_EN
      timer             <= 26'd0;
`endif
    end else begin
      state             <= nextState;
      prevSub           <= substateRx;
      count             <= nextCount;
      capLink           <= nextCapLink;
      finishRx          <= nextFinish;
      gotoRx            <= nextGoto;
      linkNumberOutRx   <= nextLinkOut;
      writeLinkNumberRx <= nextWrite;
`ifdef RX_SUBSTATE_TIMEOUT_EN
      timer             <= nextTimer;
`endif
    end
  end
endmodule
